// File: rtl/jesd204_up_tx_pkg.sv
// Shared definitions for the JESD204 TX software register map:
// word addresses, lane window geometry, field positions and reset values.
package jesd204_up_tx_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  // Global register word addresses
  localparam logic [ADDR_W-1:0] ADDR_DATA_PATH_WIDTH = 12'h010;
  localparam logic [ADDR_W-1:0] ADDR_LINK_CFG        = 12'h090;
  localparam logic [ADDR_W-1:0] ADDR_ILAS_DELAY      = 12'h091;
  localparam logic [ADDR_W-1:0] ADDR_MANUAL_SYNC     = 12'h092;
  localparam logic [ADDR_W-1:0] ADDR_STATUS          = 12'h0a0;
  localparam logic [ADDR_W-1:0] ADDR_SYNC_CNT        = 12'h0a1;

  // Per-lane window: lane i starts at LANE_BASE + LANE_STRIDE*i, ILAS words
  // occupy the upper half of the window.
  localparam logic [ADDR_W-1:0] LANE_BASE        = 12'h0c0;
  localparam logic [ADDR_W-1:0] LANE_STRIDE      = 12'd8;
  localparam logic [ADDR_W-1:0] ILAS_WORD_OFFSET = 12'd4;
  localparam int                ILAS_WORDS       = 4;

  // Field positions
  localparam int CFG_CONT_CGS_BIT  = 0;
  localparam int CFG_CONT_ILAS_BIT = 1;
  localparam int CFG_SKIP_ILAS_BIT = 2;
  localparam int CFG_MFRAMES_LSB   = 8;
  localparam int STATUS_SYNC_BIT   = 4;

  localparam logic [7:0] MFRAMES_RESET = 8'd3;

  typedef struct packed {
    logic       continuous_cgs;
    logic       continuous_ilas;
    logic       skip_ilas;
    logic [7:0] mframes_per_ilas;
    logic [3:0] ilas_delay;
  } link_cfg_t;

  localparam link_cfg_t LINK_CFG_RESET = '{
    continuous_cgs:   1'b0,
    continuous_ilas:  1'b0,
    skip_ilas:        1'b0,
    mframes_per_ilas: MFRAMES_RESET,
    ilas_delay:       4'd0
  };

  // Readback image of the link configuration word.
  function automatic logic [DATA_W-1:0] pack_link_cfg(input link_cfg_t c);
    logic [DATA_W-1:0] w;
    w = '0;
    w[CFG_CONT_CGS_BIT]                    = c.continuous_cgs;
    w[CFG_CONT_ILAS_BIT]                   = c.continuous_ilas;
    w[CFG_SKIP_ILAS_BIT]                   = c.skip_ilas;
    w[CFG_MFRAMES_LSB +: 8]                = c.mframes_per_ilas;
    return w;
  endfunction

endpackage

// File: rtl/jesd204_up_tx_lane_ilas.sv
// One lane's ILAS configuration memory: four 32-bit words, write-protected
// while the link is enabled, with a registered readback path that is zero
// unless this lane's window is being read.
module jesd204_up_tx_lane_ilas
  import jesd204_up_tx_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic              up_clk,
  input  logic              up_rstn,
  input  logic              up_wreq,
  input  logic [ADDR_W-1:0] up_waddr,
  input  logic [DATA_W-1:0] up_wdata,
  input  logic              up_cfg_is_writeable,
  input  logic              up_rreq,
  input  logic [ADDR_W-1:0] up_raddr,
  output logic [DATA_W-1:0] up_rdata,
  output logic [127:0]      ilas_data
);

  localparam logic [ADDR_W-1:0] WIN_BASE = LANE_BASE + LANE_STRIDE * 12'(LANE);

  logic [DATA_W-1:0] mem_q [ILAS_WORDS];
  logic [DATA_W-1:0] mem_d [ILAS_WORDS];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [ADDR_W-1:0] w_off, r_off, w_idx, r_idx;
  logic              w_hit, r_hit;

  assign w_off = up_waddr - WIN_BASE;
  assign r_off = up_raddr - WIN_BASE;
  assign w_idx = w_off - ILAS_WORD_OFFSET;
  assign r_idx = r_off - ILAS_WORD_OFFSET;
  assign w_hit = (up_waddr >= WIN_BASE) && (w_off >= ILAS_WORD_OFFSET) && (w_off < LANE_STRIDE);
  assign r_hit = (up_raddr >= WIN_BASE) && (r_off >= ILAS_WORD_OFFSET) && (r_off < LANE_STRIDE);

  // Next memory contents and readback word; reads see the pre-write contents.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    mem_d   = mem_q;
    rdata_d = '0;
    if (up_wreq && up_cfg_is_writeable && w_hit) begin
      mem_d[w_idx[1:0]] = up_wdata;
    end
    if (up_rreq && r_hit) begin
      rdata_d = mem_q[r_idx[1:0]];
    end
  end

  // Memory and readback registers.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      // NOTE: this memory is reset because its contents drive the core's ILAS
      // octets directly and must be defined (all zero) right after reset.
      for (int i = 0; i < ILAS_WORDS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  // Flatten the memory into the lane's 128-bit ILAS octet vector.
  always_comb begin
    ilas_data = '0;
    for (int i = 0; i < ILAS_WORDS; i++) begin
      ilas_data[32*i +: 32] = mem_q[i];
    end
  end

  assign up_rdata = rdata_q;

endmodule

// File: rtl/jesd204_up_tx_regmap.sv
// JESD204 TX link-layer register map (up_clk domain): link configuration,
// per-lane ILAS memories, manual SYNC request pulse and SYNC~ event counter.
module jesd204_up_tx_regmap
  import jesd204_up_tx_pkg::*;
#(
  parameter int NUM_LANES       = 1,
  parameter int DATA_PATH_WIDTH = 4
) (
  input  logic                   up_clk,
  input  logic                   up_rstn,
  input  logic                   up_rreq,
  input  logic [ADDR_W-1:0]      up_raddr,
  output logic                   up_rack,
  output logic [DATA_W-1:0]      up_rdata,
  input  logic                   up_wreq,
  input  logic [ADDR_W-1:0]      up_waddr,
  input  logic [DATA_W-1:0]      up_wdata,
  output logic                   up_wack,
  input  logic                   up_cfg_is_writeable,
  input  logic                   up_status_sync,
  input  logic [1:0]             up_status_state,
  output logic                   up_cfg_continuous_cgs,
  output logic                   up_cfg_continuous_ilas,
  output logic                   up_cfg_skip_ilas,
  output logic [7:0]             up_cfg_mframes_per_ilas,
  output logic [3:0]             up_cfg_ilas_delay,
  output logic                   up_ctrl_manual_sync_request,
  output logic [NUM_LANES*128-1:0] up_ilas_data
);

  link_cfg_t         cfg_q, cfg_d;
  logic [15:0]       sync_cnt_q, sync_cnt_d;
  logic              sync_hist_q, sync_hist_d;
  logic              rack_q, rack_d;
  logic              wack_q, wack_d;
  logic              sync_req_q, sync_req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] lane_rdata [NUM_LANES];
  logic [DATA_W-1:0] lane_rdata_or;
  logic              sync_fall, sync_clr;

  // Protected configuration writes; dropped while the link is enabled.
  always_comb begin
    cfg_d = cfg_q;
    if (up_wreq && up_cfg_is_writeable) begin
      case (up_waddr)
        ADDR_LINK_CFG: begin
          cfg_d.continuous_cgs   = up_wdata[CFG_CONT_CGS_BIT];
          cfg_d.continuous_ilas  = up_wdata[CFG_CONT_ILAS_BIT];
          cfg_d.skip_ilas        = up_wdata[CFG_SKIP_ILAS_BIT];
          cfg_d.mframes_per_ilas = up_wdata[CFG_MFRAMES_LSB +: 8];
        end
        ADDR_ILAS_DELAY: cfg_d.ilas_delay = up_wdata[3:0];
        default: ;
      endcase
    end
  end

  // SYNC~ falling-edge counter: saturating, any write clears, a coincident
  // edge is counted on top of the clear.
  assign sync_fall = sync_hist_q && !up_status_sync;
  assign sync_clr  = up_wreq && (up_waddr == ADDR_SYNC_CNT);

  always_comb begin
    sync_hist_d = up_status_sync;
    sync_cnt_d  = sync_cnt_q;
    if (sync_clr) begin
      sync_cnt_d = sync_fall ? 16'd1 : 16'd0;
    end else if (sync_fall && (sync_cnt_q != 16'hffff)) begin
      sync_cnt_d = sync_cnt_q + 16'd1;
    end
  end

  // Handshakes, manual sync pulse and readback of the global registers.
  always_comb begin
    rack_d     = up_rreq;
    wack_d     = up_wreq;
    sync_req_d = up_wreq && (up_waddr == ADDR_MANUAL_SYNC) && up_wdata[0];
    rdata_d    = '0;
    if (up_rreq) begin
      case (up_raddr)
        ADDR_DATA_PATH_WIDTH: rdata_d = 32'(DATA_PATH_WIDTH);
        ADDR_LINK_CFG:        rdata_d = pack_link_cfg(cfg_q);
        ADDR_ILAS_DELAY:      rdata_d = {28'd0, cfg_q.ilas_delay};
        ADDR_STATUS: begin
          rdata_d[1:0]            = up_status_state;
          rdata_d[STATUS_SYNC_BIT] = up_status_sync;
        end
        ADDR_SYNC_CNT:        rdata_d = {16'd0, sync_cnt_q};
        default: ;
      endcase
    end
  end

  // State register for configuration, counter and bus handshakes.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      cfg_q       <= LINK_CFG_RESET;
      sync_cnt_q  <= '0;
      sync_hist_q <= 1'b1;
      rack_q      <= 1'b0;
      wack_q      <= 1'b0;
      sync_req_q  <= 1'b0;
      rdata_q     <= '0;
    end else begin
      cfg_q       <= cfg_d;
      sync_cnt_q  <= sync_cnt_d;
      sync_hist_q <= sync_hist_d;
      rack_q      <= rack_d;
      wack_q      <= wack_d;
      sync_req_q  <= sync_req_d;
      rdata_q     <= rdata_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    jesd204_up_tx_lane_ilas #(
      .LANE(i)
    ) u_lane_ilas (
      .up_clk              (up_clk),
      .up_rstn             (up_rstn),
      .up_wreq             (up_wreq),
      .up_waddr            (up_waddr),
      .up_wdata            (up_wdata),
      .up_cfg_is_writeable (up_cfg_is_writeable),
      .up_rreq             (up_rreq),
      .up_raddr            (up_raddr),
      .up_rdata            (lane_rdata[i]),
      .ilas_data           (up_ilas_data[128*i +: 128])
    );
  end

  // Lane readbacks are zero outside their own window, so OR-merge them.
  always_comb begin
    lane_rdata_or = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lane_rdata_or = lane_rdata_or | lane_rdata[i];
    end
  end

  assign up_rack                     = rack_q;
  assign up_wack                     = wack_q;
  assign up_rdata                    = rdata_q | lane_rdata_or;
  assign up_ctrl_manual_sync_request = sync_req_q;
  assign up_cfg_continuous_cgs       = cfg_q.continuous_cgs;
  assign up_cfg_continuous_ilas      = cfg_q.continuous_ilas;
  assign up_cfg_skip_ilas            = cfg_q.skip_ilas;
  assign up_cfg_mframes_per_ilas     = cfg_q.mframes_per_ilas;
  assign up_cfg_ilas_delay           = cfg_q.ilas_delay;

endmodule

// File: tb/tb_jesd204_up_tx_regmap.sv
// Directed self-checking bench for jesd204_up_tx_regmap with two lanes.
module tb_jesd204_up_tx_regmap;

  localparam int NUM_LANES = 2;

  logic                      up_clk = 1'b0;
  logic                      up_rstn;
  logic                      up_rreq;
  logic [11:0]               up_raddr;
  logic                      up_rack;
  logic [31:0]               up_rdata;
  logic                      up_wreq;
  logic [11:0]               up_waddr;
  logic [31:0]               up_wdata;
  logic                      up_wack;
  logic                      up_cfg_is_writeable;
  logic                      up_status_sync;
  logic [1:0]                up_status_state;
  logic                      up_cfg_continuous_cgs;
  logic                      up_cfg_continuous_ilas;
  logic                      up_cfg_skip_ilas;
  logic [7:0]                up_cfg_mframes_per_ilas;
  logic [3:0]                up_cfg_ilas_delay;
  logic                      up_ctrl_manual_sync_request;
  logic [NUM_LANES*128-1:0]  up_ilas_data;

  int n_cmp = 0;
  int n_mis = 0;

  jesd204_up_tx_regmap #(
    .NUM_LANES(NUM_LANES),
    .DATA_PATH_WIDTH(4)
  ) dut (
    .up_clk                      (up_clk),
    .up_rstn                     (up_rstn),
    .up_rreq                     (up_rreq),
    .up_raddr                    (up_raddr),
    .up_rack                     (up_rack),
    .up_rdata                    (up_rdata),
    .up_wreq                     (up_wreq),
    .up_waddr                    (up_waddr),
    .up_wdata                    (up_wdata),
    .up_wack                     (up_wack),
    .up_cfg_is_writeable         (up_cfg_is_writeable),
    .up_status_sync              (up_status_sync),
    .up_status_state             (up_status_state),
    .up_cfg_continuous_cgs       (up_cfg_continuous_cgs),
    .up_cfg_continuous_ilas      (up_cfg_continuous_ilas),
    .up_cfg_skip_ilas            (up_cfg_skip_ilas),
    .up_cfg_mframes_per_ilas     (up_cfg_mframes_per_ilas),
    .up_cfg_ilas_delay           (up_cfg_ilas_delay),
    .up_ctrl_manual_sync_request (up_ctrl_manual_sync_request),
    .up_ilas_data                (up_ilas_data)
  );

  always #5 up_clk = ~up_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, limit 200000", $time);
    $fatal(1);
  end

  // Bus helpers: drive on the falling edge, sample the response one cycle later.
  task automatic do_write(input logic [11:0] a, input logic [31:0] d, output logic ack);
    @(negedge up_clk);
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    @(negedge up_clk);
    up_wreq = 1'b0;
    ack = up_wack;
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic ack);
    @(negedge up_clk);
    up_rreq = 1'b1; up_raddr = a;
    @(negedge up_clk);
    up_rreq = 1'b0;
    d   = up_rdata;
    ack = up_rack;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    n_cmp++; if ({up_rack, up_wack, up_ctrl_manual_sync_request} !== 3'b000) begin
      n_mis++; $display("FAIL rst_acks: got %b expected 000", {up_rack, up_wack, up_ctrl_manual_sync_request});
    end
    n_cmp++; if (up_rdata !== 32'h0) begin
      n_mis++; $display("FAIL rst_rdata: got %08h expected 00000000", up_rdata);
    end
    n_cmp++; if ({up_cfg_continuous_cgs, up_cfg_continuous_ilas, up_cfg_skip_ilas, up_cfg_mframes_per_ilas, up_cfg_ilas_delay} !== {3'b000, 8'd3, 4'd0}) begin
      n_mis++; $display("FAIL rst_cfg: got %b/%0d/%0d expected 000/3/0",
        {up_cfg_continuous_cgs, up_cfg_continuous_ilas, up_cfg_skip_ilas}, up_cfg_mframes_per_ilas, up_cfg_ilas_delay);
    end
    n_cmp++; if (up_ilas_data !== '0) begin
      n_mis++; $display("FAIL rst_ilas: got %h expected 0", up_ilas_data);
    end
    @(negedge up_clk); up_rstn = 1'b1;
    do_read(12'h090, d, a);
    n_cmp++; if ({a, d} !== {1'b1, 32'h0000_0300}) begin
      n_mis++; $display("FAIL rd_090_reset: got ack=%b data=%08h expected ack=1 data=00000300", a, d);
    end
    @(negedge up_clk);
    n_cmp++; if ({up_rack, up_rdata} !== 33'h0) begin
      n_mis++; $display("FAIL rdata_idle: got ack=%b data=%08h expected ack=0 data=0", up_rack, up_rdata);
    end
    do_read(12'h010, d, a);
    n_cmp++; if ({a, d} !== {1'b1, 32'd4}) begin
      n_mis++; $display("FAIL rd_dpw: got ack=%b data=%08h expected ack=1 data=00000004", a, d);
    end
    do_read(12'h3ff, d, a);
    n_cmp++; if ({a, d} !== {1'b1, 32'h0}) begin
      n_mis++; $display("FAIL rd_unmapped: got ack=%b data=%08h expected ack=1 data=0", a, d);
    end
    do_read(12'h0a1, d, a);
    n_cmp++; if (d !== 32'h0) begin
      n_mis++; $display("FAIL rd_cnt_reset: got %08h expected 00000000", d);
    end
  endtask

  task automatic test_cfg_protect();
    logic [31:0] d;
    logic        a;
    up_cfg_is_writeable = 1'b1;
    do_write(12'h090, 32'h0000_0705, a);
    n_cmp++; if (a !== 1'b1) begin
      n_mis++; $display("FAIL wack_open: got %b expected 1", a);
    end
    n_cmp++; if ({up_cfg_continuous_cgs, up_cfg_continuous_ilas, up_cfg_skip_ilas, up_cfg_mframes_per_ilas} !== {3'b101, 8'd7}) begin
      n_mis++; $display("FAIL cfg_write: got %b/%0d expected 101/7",
        {up_cfg_continuous_cgs, up_cfg_continuous_ilas, up_cfg_skip_ilas}, up_cfg_mframes_per_ilas);
    end
    up_cfg_is_writeable = 1'b0;
    do_write(12'h090, 32'h0, a);
    n_cmp++; if (a !== 1'b1) begin
      n_mis++; $display("FAIL wack_blocked: got %b expected 1", a);
    end
    n_cmp++; if ({up_cfg_continuous_cgs, up_cfg_continuous_ilas, up_cfg_skip_ilas, up_cfg_mframes_per_ilas} !== {3'b101, 8'd7}) begin
      n_mis++; $display("FAIL cfg_blocked: got %b/%0d expected 101/7",
        {up_cfg_continuous_cgs, up_cfg_continuous_ilas, up_cfg_skip_ilas}, up_cfg_mframes_per_ilas);
    end
    do_read(12'h090, d, a);
    n_cmp++; if (d !== 32'h0000_0705) begin
      n_mis++; $display("FAIL rd_090_blocked: got %08h expected 00000705", d);
    end
    do_write(12'h091, 32'h5, a);
    n_cmp++; if (up_cfg_ilas_delay !== 4'd0) begin
      n_mis++; $display("FAIL delay_blocked: got %0d expected 0", up_cfg_ilas_delay);
    end
    up_cfg_is_writeable = 1'b1;
    do_write(12'h091, 32'hffff_fff5, a);
    n_cmp++; if (up_cfg_ilas_delay !== 4'd5) begin
      n_mis++; $display("FAIL delay_write: got %0d expected 5", up_cfg_ilas_delay);
    end
    // Read and write of 0x091 in the same cycle: read returns the old value.
    @(negedge up_clk);
    up_rreq = 1'b1; up_raddr = 12'h091;
    up_wreq = 1'b1; up_waddr = 12'h091; up_wdata = 32'ha;
    @(negedge up_clk);
    up_rreq = 1'b0; up_wreq = 1'b0;
    n_cmp++; if ({up_rack, up_wack, up_rdata} !== {2'b11, 32'h5}) begin
      n_mis++; $display("FAIL rw_same: got rack=%b wack=%b data=%08h expected 1/1/00000005", up_rack, up_wack, up_rdata);
    end
    do_read(12'h091, d, a);
    n_cmp++; if (d !== 32'ha) begin
      n_mis++; $display("FAIL rd_091_new: got %08h expected 0000000a", d);
    end
  endtask

  task automatic test_ilas();
    logic [31:0] d;
    logic        a;
    up_cfg_is_writeable = 1'b1;
    do_write(12'h0cd, 32'ha5a5_0001, a);
    n_cmp++; if (up_ilas_data[191:160] !== 32'ha5a5_0001) begin
      n_mis++; $display("FAIL ilas_l1w1: got %08h expected a5a50001", up_ilas_data[191:160]);
    end
    do_write(12'h0c7, 32'h1234_5678, a);
    n_cmp++; if (up_ilas_data[127:96] !== 32'h1234_5678) begin
      n_mis++; $display("FAIL ilas_l0w3: got %08h expected 12345678", up_ilas_data[127:96]);
    end
    n_cmp++; if ({up_ilas_data[255:192], up_ilas_data[159:128], up_ilas_data[95:0]} !== '0) begin
      n_mis++; $display("FAIL ilas_others: got %h expected 0", up_ilas_data);
    end
    do_read(12'h0cd, d, a);
    n_cmp++; if ({a, d} !== {1'b1, 32'ha5a5_0001}) begin
      n_mis++; $display("FAIL rd_0cd: got ack=%b data=%08h expected ack=1 data=a5a50001", a, d);
    end
    do_read(12'h0c9, d, a);
    n_cmp++; if ({a, d} !== {1'b1, 32'h0}) begin
      n_mis++; $display("FAIL rd_0c9: got ack=%b data=%08h expected ack=1 data=0", a, d);
    end
    do_read(12'h0c7, d, a);
    n_cmp++; if (d !== 32'h1234_5678) begin
      n_mis++; $display("FAIL rd_0c7: got %08h expected 12345678", d);
    end
    // Lane 2 does not exist: window reads 0 and writes go nowhere.
    do_write(12'h0d4, 32'hdead_beef, a);
    do_read(12'h0d4, d, a);
    n_cmp++; if ({a, d} !== {1'b1, 32'h0}) begin
      n_mis++; $display("FAIL rd_lane2: got ack=%b data=%08h expected ack=1 data=0", a, d);
    end
    up_cfg_is_writeable = 1'b0;
    do_write(12'h0cd, 32'h0, a);
    n_cmp++; if (up_ilas_data[191:160] !== 32'ha5a5_0001) begin
      n_mis++; $display("FAIL ilas_blocked: got %08h expected a5a50001", up_ilas_data[191:160]);
    end
    up_cfg_is_writeable = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        a;
    logic [2:0]  seen;
    @(negedge up_clk);
    up_wreq = 1'b1; up_waddr = 12'h092; up_wdata = 32'h1;
    n_cmp++; if (up_ctrl_manual_sync_request !== 1'b0) begin
      n_mis++; $display("FAIL sync_req_pre: got %b expected 0", up_ctrl_manual_sync_request);
    end
    @(negedge up_clk);
    seen[0] = up_ctrl_manual_sync_request;
    @(negedge up_clk);
    up_wreq = 1'b0;
    seen[1] = up_ctrl_manual_sync_request;
    @(negedge up_clk);
    seen[2] = up_ctrl_manual_sync_request;
    n_cmp++; if (seen !== 3'b011) begin
      n_mis++; $display("FAIL sync_req_b2b: got %b (oldest in lsb) expected 011", seen);
    end
    up_cfg_is_writeable = 1'b0;
    do_write(12'h092, 32'h1, a);
    n_cmp++; if (up_ctrl_manual_sync_request !== 1'b1) begin
      n_mis++; $display("FAIL sync_req_unprot: got %b expected 1", up_ctrl_manual_sync_request);
    end
    up_cfg_is_writeable = 1'b1;
    do_write(12'h092, 32'hffff_fffe, a);
    n_cmp++; if (up_ctrl_manual_sync_request !== 1'b0) begin
      n_mis++; $display("FAIL sync_req_zero: got %b expected 0", up_ctrl_manual_sync_request);
    end
    do_read(12'h092, d, a);
    n_cmp++; if ({a, d} !== {1'b1, 32'h0}) begin
      n_mis++; $display("FAIL rd_092: got ack=%b data=%08h expected ack=1 data=0", a, d);
    end
  endtask

  task automatic test_sync_counter();
    logic [31:0] d;
    logic        a;
    for (int i = 0; i < 3; i++) begin
      @(negedge up_clk); up_status_sync = 1'b0;
      @(negedge up_clk); up_status_sync = 1'b1;
    end
    do_read(12'h0a1, d, a);
    n_cmp++; if (d !== 32'd3) begin
      n_mis++; $display("FAIL cnt_3: got %08h expected 00000003", d);
    end
    // Clear coincident with a falling edge.
    @(negedge up_clk);
    up_status_sync = 1'b0;
    up_wreq = 1'b1; up_waddr = 12'h0a1; up_wdata = 32'h0;
    @(negedge up_clk);
    up_wreq = 1'b0; up_status_sync = 1'b1;
    do_read(12'h0a1, d, a);
    n_cmp++; if (d !== 32'd1) begin
      n_mis++; $display("FAIL cnt_clr_edge: got %08h expected 00000001", d);
    end
    up_cfg_is_writeable = 1'b0;
    do_write(12'h0a1, 32'h0, a);
    do_read(12'h0a1, d, a);
    n_cmp++; if (d !== 32'd0) begin
      n_mis++; $display("FAIL cnt_clr: got %08h expected 00000000", d);
    end
    up_cfg_is_writeable = 1'b1;
    // Saturation: preload near the top, then apply 10 more edges.
    @(negedge up_clk);
    force dut.sync_cnt_q = 16'hfffa;
    #1;
    release dut.sync_cnt_q;
    for (int i = 0; i < 10; i++) begin
      @(negedge up_clk); up_status_sync = 1'b0;
      @(negedge up_clk); up_status_sync = 1'b1;
    end
    do_read(12'h0a1, d, a);
    n_cmp++; if (d !== 32'h0000_ffff) begin
      n_mis++; $display("FAIL cnt_sat: got %08h expected 0000ffff", d);
    end
  endtask

  task automatic test_status();
    logic [31:0] d;
    logic        a;
    up_status_state = 2'd3; up_status_sync = 1'b1;
    do_read(12'h0a0, d, a);
    n_cmp++; if (d !== 32'h13) begin
      n_mis++; $display("FAIL status_a: got %08h expected 00000013", d);
    end
    up_status_state = 2'd2; up_status_sync = 1'b0;
    do_read(12'h0a0, d, a);
    n_cmp++; if (d !== 32'h02) begin
      n_mis++; $display("FAIL status_b: got %08h expected 00000002", d);
    end
    up_status_sync = 1'b1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] d;
    logic        a;
    @(negedge up_clk);
    up_rreq = 1'b1; up_raddr = 12'h090;
    #3;
    up_rstn = 1'b0;
    #1;
    n_cmp++; if ({up_cfg_continuous_cgs, up_cfg_skip_ilas, up_cfg_mframes_per_ilas, up_cfg_ilas_delay} !== {2'b00, 8'd3, 4'd0}) begin
      n_mis++; $display("FAIL async_cfg: got %b/%0d/%0d expected 00/3/0",
        {up_cfg_continuous_cgs, up_cfg_skip_ilas}, up_cfg_mframes_per_ilas, up_cfg_ilas_delay);
    end
    n_cmp++; if (up_ilas_data !== '0) begin
      n_mis++; $display("FAIL async_ilas: got %h expected 0", up_ilas_data);
    end
    @(negedge up_clk);
    up_rreq = 1'b0;
    n_cmp++; if ({up_rack, up_rdata} !== 33'h0) begin
      n_mis++; $display("FAIL abort_rack: got ack=%b data=%08h expected ack=0 data=0", up_rack, up_rdata);
    end
    @(negedge up_clk);
    up_rstn = 1'b1;
    do_read(12'h090, d, a);
    n_cmp++; if ({a, d} !== {1'b1, 32'h0000_0300}) begin
      n_mis++; $display("FAIL rd_090_post: got ack=%b data=%08h expected ack=1 data=00000300", a, d);
    end
    do_read(12'h0a1, d, a);
    n_cmp++; if (d !== 32'h0) begin
      n_mis++; $display("FAIL cnt_post: got %08h expected 00000000", d);
    end
  endtask

  initial begin
    up_rstn = 1'b0;
    up_rreq = 1'b0; up_raddr = '0;
    up_wreq = 1'b0; up_waddr = '0; up_wdata = '0;
    up_cfg_is_writeable = 1'b1;
    up_status_sync = 1'b1;
    up_status_state = 2'd0;
    repeat (3) @(negedge up_clk);
    test_reset();
    test_cfg_protect();
    test_ilas();
    test_back_to_back();
    test_sync_counter();
    test_status();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
